// File: rtl/rle_expand.sv
// rle_expand: run-length decoder, token FIFO feeding a byte expander
//   CLK/RST                                : clock, synchronous active-high reset
//   IN_VALID/IN_DATA/IN_COUNT/IN_READY     : {byte, run} token input, count 0 means 8
//   OUT_DATA/OUT_VALID/OUT_READY/OUT_LAST  : expanded byte stream, LAST marks end of run
//   LEVEL/OVERFLOW                         : FIFO occupancy, sticky dropped-token flag
module rle_expand #(
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [7:0]        IN_DATA,
  input  logic [2:0]        IN_COUNT,
  output logic              IN_READY,
  output logic [7:0]        OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic [ADDR_W:0]   LEVEL,
  output logic              OVERFLOW
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  logic [10:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_q, rd_q;
  logic [ADDR_W:0] lvl_q, lvl_d;
  logic [0:0] state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [3:0] rem_q, rem_d;
  logic ovf_q;
  logic push, pop, hs, run_end;
  logic [10:0] head;
  assign IN_READY  = lvl_q != FULL_LVL;
  assign push      = IN_VALID && IN_READY;
  assign hs        = state_q == EMIT && OUT_READY;
  assign run_end   = hs && rem_q == 4'd1;
  assign pop       = lvl_q != '0 && (state_q == IDLE || run_end);
  assign head      = mem_q[rd_q];
  assign OUT_VALID = state_q == EMIT;
  assign OUT_LAST  = state_q == EMIT && rem_q == 4'd1;
  assign OUT_DATA  = data_q;
  assign LEVEL     = lvl_q;
  assign OVERFLOW  = ovf_q;
  // count 0 maps to 8 by prefixing the "is zero" bit onto the 3-bit count
  always_comb begin
    state_d = pop ? EMIT : run_end ? IDLE : state_q;
    data_d  = pop ? head[10:3] : data_q;
    rem_d   = pop ? {head[2:0] == 3'd0, head[2:0]} : hs ? rem_q - 4'd1 : rem_q;
    lvl_d   = lvl_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= push ? wr_q + 1'b1 : wr_q;
      rd_q    <= pop ? rd_q + 1'b1 : rd_q;
      lvl_q   <= lvl_d;
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_q | (IN_VALID & ~IN_READY);
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST && push) mem_q[wr_q] <= {IN_DATA, IN_COUNT};
  end
endmodule

// File: tb/tb_rle_expand.sv
// tb_rle_expand: randomized and directed check of rle_expand against a queue-based model
module tb_rle_expand;
  localparam int ADDR_W = 3;
  localparam int DEPTH = 1 << ADDR_W;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic IN_VALID = 1'b0;
  logic [7:0] IN_DATA = '0;
  logic [2:0] IN_COUNT = '0;
  logic IN_READY;
  logic [7:0] OUT_DATA;
  logic OUT_VALID;
  logic OUT_READY = 1'b0;
  logic OUT_LAST;
  logic [ADDR_W:0] LEVEL;
  logic OVERFLOW;
  rle_expand #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_COUNT(IN_COUNT),
    .IN_READY(IN_READY), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_LAST(OUT_LAST), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW)
  );
  always #5 CLK = ~CLK;
  int n_chk = 0;
  int n_err = 0;
  logic [10:0] m_tq [$];
  logic [8:0] exp_b [$];
  bit m_act = 0;
  int m_rem = 0;
  logic [7:0] m_data = '0;
  bit m_ovf = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input bit v, input logic [7:0] d, input logic [2:0] c, input bit r, input bit rst);
    bit hs, full, accept;
    int n;
    logic [10:0] t;
    if (rst) begin
      m_tq.delete(); exp_b.delete();
      m_act = 0; m_rem = 0; m_data = '0; m_ovf = 0;
      return;
    end
    hs = m_act && r;
    full = m_tq.size() == DEPTH;
    accept = v && !full;
    if (v && full) m_ovf = 1;
    if (hs && m_rem > 1) m_rem--;
    else if (m_tq.size() > 0 && (!m_act || hs)) begin
      t = m_tq.pop_front();
      m_data = t[10:3];
      m_rem = (t[2:0] == 0) ? 8 : int'(t[2:0]);
      m_act = 1;
    end else if (hs) begin
      m_act = 0;
      m_rem = 0;
    end
    if (accept) begin
      m_tq.push_back({d, c});
      n = (c == 0) ? 8 : int'(c);
      for (int i = 1; i <= n; i++) exp_b.push_back({i == n, d});
    end
  endtask
  task automatic cyc(input bit v, input logic [7:0] d, input logic [2:0] c, input bit r, input bit rst);
    logic [8:0] e;
    IN_VALID = v; IN_DATA = d; IN_COUNT = c; OUT_READY = r; RST = rst;
    if (!rst && OUT_VALID && r) begin
      if (exp_b.size() == 0) chk("stream_extra", 32'(OUT_DATA), 32'hFFFF);
      else begin
        e = exp_b.pop_front();
        chk("stream_byte", 32'(OUT_DATA), 32'(e[7:0]));
        chk("stream_last", 32'(OUT_LAST), 32'(e[8]));
      end
    end
    @(posedge CLK);
    model(v, d, c, r, rst);
    #1;
    chk("out_valid", 32'(OUT_VALID), 32'(m_act));
    if (m_act) chk("out_data", 32'(OUT_DATA), 32'(m_data));
    chk("out_last", 32'(OUT_LAST), 32'(m_act && m_rem == 1));
    chk("level", 32'(LEVEL), 32'(m_tq.size()));
    chk("in_ready", 32'(IN_READY), 32'(m_tq.size() != DEPTH));
    chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
  endtask
  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 3'd0, r, 0);
  endtask
  initial begin
    cyc(0, 8'h00, 3'd0, 0, 1);
    cyc(1, 8'hAA, 3'd2, 1, 1);
    chk("reset_data", 32'(OUT_DATA), 32'h0);
    cyc(1, 8'h41, 3'd3, 1, 0);
    idle(6, 1);
    cyc(1, 8'h7E, 3'd0, 1, 0);
    idle(10, 1);
    cyc(1, 8'h01, 3'd1, 1, 0);
    cyc(1, 8'h02, 3'd2, 1, 0);
    cyc(1, 8'h03, 3'd1, 1, 0);
    idle(6, 1);
    cyc(1, 8'h55, 3'd4, 1, 0);
    idle(3, 1);
    idle(5, 0);
    idle(5, 1);
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'h80 + i), 3'(i), 0, 0);
    idle(3, 0);
    idle(80, 1);
    cyc(1, 8'h99, 3'd6, 1, 0);
    cyc(1, 8'h11, 3'd3, 1, 0);
    cyc(1, 8'h22, 3'd5, 1, 0);
    cyc(0, 8'h00, 3'd0, 1, 1);
    cyc(1, 8'h10, 3'd2, 1, 0);
    idle(5, 1);
    for (int i = 0; i < 3000; i++) begin
      bit v, r, rst;
      int ph = (i / 500) % 3;
      v = ($urandom_range(0, 3) != 0);
      r = (ph == 0) ? 1'b1 : (ph == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 399) == 0);
      cyc(v, 8'($urandom), 3'($urandom), r, rst);
    end
    idle(80, 1);
    chk("drained", 32'(exp_b.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
